mem_stage_ctrl: RTL and testbench
=================================

// Module: mem_stage_ctrl
// PURPOSE
//  Consumer end of the EX/MEM pipeline register: accepts OpCode/Rd/BranchResult/AluResult
//  each cycle, runs data-memory loads and stores over a req/ack handshake, and drives the
//  MEM/WB register outputs. Stalls upstream while a memory access is outstanding.
//  Non-memory ops pass through with 1-cycle latency.
// PARAMETERS
//  OP_LOAD        5'b01000  opcode treated as a load (WbData = memory read data)
//  OP_STORE       5'b01001  opcode treated as a store (no writeback)
//  OP_NOP         5'b00000  opcode producing no writeback
//  TIMEOUT_CYCLES 16        max WAIT cycles before abort (MEM_TIMEOUT_EN only)
// PORTS
//  clk              in   1   clock; all state updates on posedge
//  rst              in   1   synchronous, active-high reset
//  OpCode           in   5   opcode from EX/MEM
//  RdOut            in   9   destination register field from EX/MEM
//  BranchResult     in   7   branch result from EX/MEM
//  AluResult        in   32  ALU result / memory address from EX/MEM
//  StoreData        in   32  store write data
//  StallOut         out  1   1 = upstream must hold EX/MEM contents
//  MemReq           out  1   memory request, held until MemAck
//  MemWe            out  1   1 = write (store), 0 = read (load); valid with MemReq
//  MemAddr          out  32  memory address; valid with MemReq
//  MemWData         out  32  store data; valid with MemReq and MemWe
//  MemAck           in   1   memory completion; sampled only while MemReq=1
//  MemRData         in   32  load data; valid with MemAck
//  OpCodeOutWB      out  5   opcode to MEM/WB
//  RdOutWB          out  9   destination register to MEM/WB
//  BranchResultOutWB out 7   branch result to MEM/WB
//  WbDataOut        out  32  writeback data
//  WbValid          out  1   1 = writeback register this cycle
//  MemErr           out  1   sticky error flag (MEM_TIMEOUT_EN only; else tied 0)
// BEHAVIOUR
//  - Reset: state=IDLE; MemReq,MemWe,WbValid,MemErr,StallOut=0; MemAddr,MemWData,
//    WbDataOut=0; OpCodeOutWB=OP_NOP; RdOutWB,BranchResultOutWB=0. Reset mid-WAIT drops
//    MemReq on the reset edge; the pending access is discarded, no writeback.
//  - FSM IDLE/WAIT. StallOut = (state==WAIT), combinational.
//  - IDLE, OpCode non-memory: next edge registers OpCode/Rd/BranchResult to WB outputs,
//    WbDataOut=AluResult, WbValid=(OpCode!=OP_NOP). Latency 1.
//  - IDLE, OpCode==OP_LOAD/OP_STORE: next edge captures op/Rd/BranchResult, MemAddr=
//    AluResult, MemWData=StoreData, MemWe=(store), MemReq=1, ->WAIT; that edge emits a
//    bubble on WB outputs (WbValid=0, OpCodeOutWB=OP_NOP).
//  - WAIT, MemAck=0: hold all Mem* outputs; WB outputs bubble each cycle.
//  - WAIT, MemAck=1: next edge MemReq=0, ->IDLE, WB outputs = captured op/Rd/Branch;
//    load: WbDataOut=MemRData, WbValid=1; store: WbDataOut=MemAddr, WbValid=0.
//    Load latency = accept edge + wait cycles + 1.
//  - MemAck while MemReq=0 is ignored. Inputs are ignored in WAIT (upstream is held).
//  - Back-to-back memory ops: IDLE after ack accepts the held next op the same cycle.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined: WAIT counter counts from 0; if TIMEOUT_CYCLES cycles elapse
//    without MemAck, next edge drops MemReq, ->IDLE, sets MemErr=1 (sticky until rst),
//    emits captured op with WbValid=0, WbDataOut=0. Counter cleared on entry to WAIT.
//  MEM_TIMEOUT_EN undefined: no counter, WAIT unbounded, MemErr tied 0.
// TESTING
//  1. rst=1 for 2 cycles mid-WAIT -> MemReq=0, WbValid=0, OpCodeOutWB=OP_NOP, StallOut=0.
//  2. ALU op 5'b00011, Rd=9'h05, AluResult=32'hDEAD_BEEF -> next cycle WbValid=1,
//     RdOutWB=9'h05, WbDataOut=32'hDEAD_BEEF, StallOut never asserted.
//  3. LOAD addr 32'h100, ack after 3 WAIT cycles with MemRData=32'h1234 -> StallOut high
//     3+1 cycles, MemAddr=32'h100, MemWe=0; then WbValid=1, WbDataOut=32'h1234.
//  4. STORE addr 32'h200 data 32'hA5A5_A5A5, ack immediately -> MemWe=1, MemWData=32'hA5A5_A5A5
//     for one WAIT cycle, WbValid=0 throughout.
//  5. LOAD then LOAD back-to-back, each acked after 1 cycle -> two WbValid pulses with
//     correct data/Rd in order; spurious MemAck in IDLE ignored.
//  6. MEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> MemReq drops after 16 WAIT cycles,
//     MemErr=1 sticky, WbValid=0; next ALU op completes normally.

Source files
------------

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory bus between the MEM pipeline stage and the data memory.
//   master modport: the stage (drives the request, consumes the ack/read data)
//   slave  modport: the memory (consumes the request, drives the ack/read data)
// Signals:
//   MemReq   request, held high until MemAck
//   MemWe    1 = write (store), 0 = read (load); valid with MemReq
//   MemAddr  32-bit address; valid with MemReq
//   MemWData 32-bit store data; valid with MemReq and MemWe
//   MemAck   completion strobe from memory
//   MemRData 32-bit load data; valid with MemAck
interface mem_stage_ctrl_if;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic        MemAck;
  logic [31:0] MemRData;

  modport master (
    output MemReq, MemWe, MemAddr, MemWData,
    input  MemAck, MemRData
  );

  modport slave (
    input  MemReq, MemWe, MemAddr, MemWData,
    output MemAck, MemRData
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: consumer end of the EX/MEM register. Non-memory ops pass to the
// MEM/WB outputs with one cycle of latency; loads and stores are issued on the data
// memory bus (req/ack) while StallOut holds upstream, then retired to MEM/WB.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   OpCode/RdOut/BranchResult/AluResult/StoreData   EX/MEM inputs
//   StallOut            1 while a memory access is outstanding
//   mem                 data-memory bus (master side)
//   OpCodeOutWB/RdOutWB/BranchResultOutWB/WbDataOut/WbValid   MEM/WB outputs
//   MemErr              sticky access-timeout flag
// Optional feature: define MEM_TIMEOUT_EN to abort a memory access that has waited
// TIMEOUT_CYCLES cycles without MemAck; otherwise WAIT is unbounded and MemErr is 0.
module mem_stage_ctrl #(
  parameter logic [4:0] OP_LOAD        = 5'b01000,
  parameter logic [4:0] OP_STORE       = 5'b01001,
  parameter logic [4:0] OP_NOP         = 5'b00000,
  parameter int         TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            OpCode,
  input  logic [8:0]            RdOut,
  input  logic [6:0]            BranchResult,
  input  logic [31:0]           AluResult,
  input  logic [31:0]           StoreData,
  output logic                  StallOut,
  mem_stage_ctrl_if.master      mem,
  output logic [4:0]            OpCodeOutWB,
  output logic [8:0]            RdOutWB,
  output logic [6:0]            BranchResultOutWB,
  output logic [31:0]           WbDataOut,
  output logic                  WbValid,
  output logic                  MemErr
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t      state_reg, state_next;
  logic        req_reg, req_next;
  logic        we_reg, we_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [4:0]  cap_op_reg, cap_op_next;
  logic [8:0]  cap_rd_reg, cap_rd_next;
  logic [6:0]  cap_br_reg, cap_br_next;
  logic [4:0]  op_wb_reg, op_wb_next;
  logic [8:0]  rd_wb_reg, rd_wb_next;
  logic [6:0]  br_wb_reg, br_wb_next;
  logic [31:0] data_wb_reg, data_wb_next;
  logic        valid_wb_reg, valid_wb_next;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             err_reg, err_next;
`endif

  always_comb begin
    state_next    = state_reg;
    req_next      = req_reg;
    we_next       = we_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    cap_op_next   = cap_op_reg;
    cap_rd_next   = cap_rd_reg;
    cap_br_next   = cap_br_reg;
    // WB outputs default to a bubble; only a retiring op overrides them.
    op_wb_next    = OP_NOP;
    rd_wb_next    = '0;
    br_wb_next    = '0;
    data_wb_next  = '0;
    valid_wb_next = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_next      = cnt_reg;
    err_next      = err_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (OpCode == OP_LOAD || OpCode == OP_STORE) begin
          cap_op_next = OpCode;
          cap_rd_next = RdOut;
          cap_br_next = BranchResult;
          addr_next   = AluResult;
          wdata_next  = StoreData;
          we_next     = (OpCode == OP_STORE);
          req_next    = 1'b1;
          state_next  = ST_WAIT;
`ifdef MEM_TIMEOUT_EN
          cnt_next    = '0;
`endif
        end else begin
          op_wb_next    = OpCode;
          rd_wb_next    = RdOut;
          br_wb_next    = BranchResult;
          data_wb_next  = AluResult;
          valid_wb_next = (OpCode != OP_NOP);
        end
      end

      ST_WAIT: begin
        // EX/MEM inputs are frozen upstream here, so they are not looked at.
        if (mem.MemAck) begin
          req_next   = 1'b0;
          state_next = ST_IDLE;
          op_wb_next = cap_op_reg;
          rd_wb_next = cap_rd_reg;
          br_wb_next = cap_br_reg;
          if (cap_op_reg == OP_LOAD) begin
            data_wb_next  = mem.MemRData;
            valid_wb_next = 1'b1;
          end else begin
            // Stores retire the address for visibility but write nothing back.
            data_wb_next  = addr_reg;
            valid_wb_next = 1'b0;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_reg == CNT_LAST) begin
          req_next   = 1'b0;
          state_next = ST_IDLE;
          err_next   = 1'b1;
          op_wb_next = cap_op_reg;
          rd_wb_next = cap_rd_reg;
          br_wb_next = cap_br_reg;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
`endif
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      req_reg      <= 1'b0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      cap_op_reg   <= OP_NOP;
      cap_rd_reg   <= '0;
      cap_br_reg   <= '0;
      op_wb_reg    <= OP_NOP;
      rd_wb_reg    <= '0;
      br_wb_reg    <= '0;
      data_wb_reg  <= '0;
      valid_wb_reg <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_reg      <= '0;
      err_reg      <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      req_reg      <= req_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      cap_op_reg   <= cap_op_next;
      cap_rd_reg   <= cap_rd_next;
      cap_br_reg   <= cap_br_next;
      op_wb_reg    <= op_wb_next;
      rd_wb_reg    <= rd_wb_next;
      br_wb_reg    <= br_wb_next;
      data_wb_reg  <= data_wb_next;
      valid_wb_reg <= valid_wb_next;
`ifdef MEM_TIMEOUT_EN
      cnt_reg      <= cnt_next;
      err_reg      <= err_next;
`endif
    end
  end

  assign StallOut          = (state_reg == ST_WAIT);
  assign mem.MemReq        = req_reg;
  assign mem.MemWe         = we_reg;
  assign mem.MemAddr       = addr_reg;
  assign mem.MemWData      = wdata_reg;
  assign OpCodeOutWB       = op_wb_reg;
  assign RdOutWB           = rd_wb_reg;
  assign BranchResultOutWB = br_wb_reg;
  assign WbDataOut         = data_wb_reg;
  assign WbValid           = valid_wb_reg;
`ifdef MEM_TIMEOUT_EN
  assign MemErr            = err_reg;
`else
  assign MemErr            = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: a table of per-cycle vectors covering ALU/NOP
// pass-through, load with wait states, immediate store, back-to-back loads and
// spurious acks, plus hand-written reset-mid-WAIT and long-wait/timeout sequences.
module tb_mem_stage_ctrl;

  localparam logic [4:0] L_OP = 5'b01000;
  localparam logic [4:0] S_OP = 5'b01001;
  localparam logic [4:0] N_OP = 5'b00000;

  logic        clk;
  logic        rst;
  logic [4:0]  OpCode;
  logic [8:0]  RdOut;
  logic [6:0]  BranchResult;
  logic [31:0] AluResult;
  logic [31:0] StoreData;
  logic        StallOut;
  logic [4:0]  OpCodeOutWB;
  logic [8:0]  RdOutWB;
  logic [6:0]  BranchResultOutWB;
  logic [31:0] WbDataOut;
  logic        WbValid;
  logic        MemErr;

  mem_stage_ctrl_if mem_bus ();

  mem_stage_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .OpCode            (OpCode),
    .RdOut             (RdOut),
    .BranchResult      (BranchResult),
    .AluResult         (AluResult),
    .StoreData         (StoreData),
    .StallOut          (StallOut),
    .mem               (mem_bus),
    .OpCodeOutWB       (OpCodeOutWB),
    .RdOutWB           (RdOutWB),
    .BranchResultOutWB (BranchResultOutWB),
    .WbDataOut         (WbDataOut),
    .WbValid           (WbValid),
    .MemErr            (MemErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [8:0]  rd;
    logic [6:0]  br;
    logic [31:0] alu;
    logic [31:0] sd;
    logic        ack;
    logic [31:0] rdata;
    logic        e_stall;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_valid;
    logic [4:0]  e_op;
    logic [8:0]  e_rd;
    logic [6:0]  e_br;
    logic [31:0] e_data;
    logic        full;   // 1: check Rd/Branch/data too (retiring op), 0: bubble
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic [8:0] rd, input logic [6:0] br,
                       input logic [31:0] alu, input logic [31:0] sd,
                       input logic ack, input logic [31:0] rdata);
    OpCode          = op;
    RdOut           = rd;
    BranchResult    = br;
    AluResult       = alu;
    StoreData       = sd;
    mem_bus.MemAck  = ack;
    mem_bus.MemRData = rdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{5'h03, 9'h005, 7'h11, 32'hDEADBEEF, '0, 1'b0, '0,
                 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 5'h03, 9'h005, 7'h11, 32'hDEADBEEF, 1'b1};
    vecs[1]  = '{N_OP, 9'h007, 7'h00, 32'h1, '0, 1'b0, '0,
                 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, N_OP, 9'h007, 7'h00, 32'h1, 1'b1};
    // Load accepted; the ack seen in IDLE must be ignored.
    vecs[2]  = '{L_OP, 9'h00A, 7'h02, 32'h100, '0, 1'b1, 32'hFFFF,
                 1'b1, 1'b1, 1'b0, 32'h100, '0, 1'b0, N_OP, '0, '0, '0, 1'b0};
    vecs[3]  = '{5'h04, 9'h00B, 7'h00, 32'h55, '0, 1'b0, '0,
                 1'b1, 1'b1, 1'b0, 32'h100, '0, 1'b0, N_OP, '0, '0, '0, 1'b0};
    vecs[4]  = vecs[3];
    vecs[5]  = vecs[3];
    vecs[6]  = '{5'h04, 9'h00B, 7'h00, 32'h55, '0, 1'b1, 32'h1234,
                 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, L_OP, 9'h00A, 7'h02, 32'h1234, 1'b1};
    vecs[7]  = '{5'h04, 9'h00B, 7'h00, 32'h55, '0, 1'b0, '0,
                 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 5'h04, 9'h00B, 7'h00, 32'h55, 1'b1};
    vecs[8]  = '{S_OP, 9'h00C, 7'h03, 32'h200, 32'hA5A5A5A5, 1'b0, '0,
                 1'b1, 1'b1, 1'b1, 32'h200, 32'hA5A5A5A5, 1'b0, N_OP, '0, '0, '0, 1'b0};
    vecs[9]  = '{N_OP, '0, '0, '0, '0, 1'b1, 32'hCAFE,
                 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, S_OP, 9'h00C, 7'h03, 32'h200, 1'b1};
    vecs[10] = '{L_OP, 9'h00D, 7'h04, 32'h300, '0, 1'b0, '0,
                 1'b1, 1'b1, 1'b0, 32'h300, '0, 1'b0, N_OP, '0, '0, '0, 1'b0};
    vecs[11] = '{L_OP, 9'h00E, 7'h05, 32'h304, '0, 1'b0, '0,
                 1'b1, 1'b1, 1'b0, 32'h300, '0, 1'b0, N_OP, '0, '0, '0, 1'b0};
    vecs[12] = '{L_OP, 9'h00E, 7'h05, 32'h304, '0, 1'b1, 32'hAAAA0001,
                 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, L_OP, 9'h00D, 7'h04, 32'hAAAA0001, 1'b1};
    vecs[13] = '{L_OP, 9'h00E, 7'h05, 32'h304, '0, 1'b0, '0,
                 1'b1, 1'b1, 1'b0, 32'h304, '0, 1'b0, N_OP, '0, '0, '0, 1'b0};
    vecs[14] = '{N_OP, '0, '0, '0, '0, 1'b0, '0,
                 1'b1, 1'b1, 1'b0, 32'h304, '0, 1'b0, N_OP, '0, '0, '0, 1'b0};
    vecs[15] = '{N_OP, '0, '0, '0, '0, 1'b1, 32'hBBBB0002,
                 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, L_OP, 9'h00E, 7'h05, 32'hBBBB0002, 1'b1};
    vecs[16] = '{N_OP, '0, '0, '0, '0, 1'b1, 32'h7777,
                 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, N_OP, '0, '0, '0, 1'b1};

    // Reset state
    rst = 1'b1;
    drive(N_OP, '0, '0, '0, '0, 1'b0, '0);
    step();
    step();
    $display("reset: stall=%b req=%b valid=%b op=%h err=%b", StallOut, mem_bus.MemReq,
             WbValid, OpCodeOutWB, MemErr);
    chk("rst_stall", 32'(StallOut), 32'h0);
    chk("rst_req",   32'(mem_bus.MemReq), 32'h0);
    chk("rst_we",    32'(mem_bus.MemWe), 32'h0);
    chk("rst_addr",  mem_bus.MemAddr, 32'h0);
    chk("rst_valid", 32'(WbValid), 32'h0);
    chk("rst_op",    32'(OpCodeOutWB), 32'(N_OP));
    chk("rst_data",  WbDataOut, 32'h0);
    chk("rst_err",   32'(MemErr), 32'h0);
    rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].op, vecs[i].rd, vecs[i].br, vecs[i].alu, vecs[i].sd,
            vecs[i].ack, vecs[i].rdata);
      step();
      $display("vec %0d: op_in=%h ack=%b -> stall=%b req=%b we=%b addr=%h valid=%b op=%h rd=%h data=%h",
               i, vecs[i].op, vecs[i].ack, StallOut, mem_bus.MemReq, mem_bus.MemWe,
               mem_bus.MemAddr, WbValid, OpCodeOutWB, RdOutWB, WbDataOut);
      chk($sformatf("v%0d_stall", i), 32'(StallOut), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d_req", i),   32'(mem_bus.MemReq), 32'(vecs[i].e_req));
      chk($sformatf("v%0d_valid", i), 32'(WbValid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_op", i),    32'(OpCodeOutWB), 32'(vecs[i].e_op));
      if (vecs[i].e_req) begin
        chk($sformatf("v%0d_we", i),   32'(mem_bus.MemWe), 32'(vecs[i].e_we));
        chk($sformatf("v%0d_addr", i), mem_bus.MemAddr, vecs[i].e_addr);
        if (vecs[i].e_we)
          chk($sformatf("v%0d_wdata", i), mem_bus.MemWData, vecs[i].e_wdata);
      end
      if (vecs[i].full) begin
        chk($sformatf("v%0d_rd", i),   32'(RdOutWB), 32'(vecs[i].e_rd));
        chk($sformatf("v%0d_br", i),   32'(BranchResultOutWB), 32'(vecs[i].e_br));
        chk($sformatf("v%0d_data", i), WbDataOut, vecs[i].e_data);
      end
    end

    // Reset held for two cycles while a load is outstanding
    drive(L_OP, 9'h011, 7'h01, 32'h500, '0, 1'b0, '0);
    step();
    chk("rw_enter_stall", 32'(StallOut), 32'h1);
    drive(N_OP, '0, '0, '0, '0, 1'b0, '0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    $display("reset mid-wait: stall=%b req=%b valid=%b op=%h", StallOut, mem_bus.MemReq,
             WbValid, OpCodeOutWB);
    chk("rw_req",   32'(mem_bus.MemReq), 32'h0);
    chk("rw_valid", 32'(WbValid), 32'h0);
    chk("rw_op",    32'(OpCodeOutWB), 32'(N_OP));
    chk("rw_stall", 32'(StallOut), 32'h0);
    // A late ack for the discarded access must not produce a writeback.
    drive(N_OP, '0, '0, '0, '0, 1'b1, 32'h9999);
    step();
    $display("after reset late ack: valid=%b op=%h", WbValid, OpCodeOutWB);
    chk("rw_late_valid", 32'(WbValid), 32'h0);
    chk("rw_late_op",    32'(OpCodeOutWB), 32'(N_OP));

`ifdef MEM_TIMEOUT_EN
    // Load with no ack: abort after TIMEOUT_CYCLES WAIT cycles
    begin
      int n;
      drive(L_OP, 9'h01F, 7'h06, 32'h400, '0, 1'b0, '0);
      step();
      chk("to_enter_stall", 32'(StallOut), 32'h1);
      drive(5'h05, 9'h010, 7'h00, 32'h77, '0, 1'b0, '0);
      n = 0;
      while (StallOut && n < 40) begin
        step();
        n++;
      end
      $display("timeout: wait cycles=%0d req=%b err=%b valid=%b op=%h data=%h", n,
               mem_bus.MemReq, MemErr, WbValid, OpCodeOutWB, WbDataOut);
      chk("to_cycles", 32'(n), 32'd16);
      chk("to_req",    32'(mem_bus.MemReq), 32'h0);
      chk("to_err",    32'(MemErr), 32'h1);
      chk("to_valid",  32'(WbValid), 32'h0);
      chk("to_op",     32'(OpCodeOutWB), 32'(L_OP));
      chk("to_rd",     32'(RdOutWB), 32'h01F);
      chk("to_data",   WbDataOut, 32'h0);
      step();
      $display("after timeout ALU: valid=%b rd=%h data=%h err=%b", WbValid, RdOutWB,
               WbDataOut, MemErr);
      chk("to_alu_valid", 32'(WbValid), 32'h1);
      chk("to_alu_rd",    32'(RdOutWB), 32'h010);
      chk("to_alu_data",  WbDataOut, 32'h77);
      chk("to_err_sticky", 32'(MemErr), 32'h1);
    end
`else
    // Without the timeout, a long wait stays stalled and MemErr stays low
    begin
      drive(L_OP, 9'h01F, 7'h06, 32'h400, '0, 1'b0, '0);
      step();
      drive(5'h05, 9'h010, 7'h00, 32'h77, '0, 1'b0, '0);
      for (int k = 0; k < 20; k++) step();
      $display("long wait: stall=%b req=%b err=%b", StallOut, mem_bus.MemReq, MemErr);
      chk("lw_stall", 32'(StallOut), 32'h1);
      chk("lw_req",   32'(mem_bus.MemReq), 32'h1);
      chk("lw_err",   32'(MemErr), 32'h0);
      mem_bus.MemAck   = 1'b1;
      mem_bus.MemRData = 32'h0BAD_F00D;
      step();
      $display("long wait ack: valid=%b rd=%h data=%h", WbValid, RdOutWB, WbDataOut);
      chk("lw_valid", 32'(WbValid), 32'h1);
      chk("lw_rd",    32'(RdOutWB), 32'h01F);
      chk("lw_data",  WbDataOut, 32'h0BADF00D);
      chk("lw_stall_end", 32'(StallOut), 32'h0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
